// File: rtl/bmu_sched.sv
// Branch-metric engine for the LRPT Viterbi decoder: one shared 8x8 squarer is
// stepped over four cycles per soft-symbol pair to produce four Euclidean metrics.
module bmu_sched #(
   parameter int unsigned STATE_MET_WIDTH = 20,
   parameter int unsigned BLOCK_LEN       = 64,
   parameter bit          NORMALIZE       = 1'b0
) (
   input  logic                       clk,
   input  logic                       sys_rst,
   input  logic [7:0]                 sym_i,
   input  logic [7:0]                 sym_q,
   input  logic                       sym_valid,
   output logic                       sym_ready,
   output logic [STATE_MET_WIDTH-1:0] met_00,
   output logic [STATE_MET_WIDTH-1:0] met_01,
   output logic [STATE_MET_WIDTH-1:0] met_10,
   output logic [STATE_MET_WIDTH-1:0] met_11,
   output logic                       met_valid,
   input  logic                       met_ready,
   output logic                       blk_end
);

   localparam int unsigned CntW = (BLOCK_LEN > 2) ? $clog2(BLOCK_LEN) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(BLOCK_LEN - 1);

   if (STATE_MET_WIDTH < 17) begin : g_met_width_check
      $error("bmu_sched: STATE_MET_WIDTH must be >= 17");
   end
   if (BLOCK_LEN < 2) begin : g_block_len_check
      $error("bmu_sched: BLOCK_LEN must be >= 2");
   end

   typedef enum logic [1:0] {StIdle, StSq, StSum, StOut} state_t;

   state_t          state;
   logic [1:0]      idx;
   logic [7:0]      lat_i;
   logic [7:0]      lat_q;
   logic [15:0]     sq0, sq1, sq2, sq3;
   logic [CntW-1:0] cnt;

   logic [7:0]  sq_op;
   logic [15:0] sq_res;
   logic [16:0] sum00, sum01, sum10, sum11;
   logic [16:0] min_lo, min_hi, min_all;
   logic [16:0] norm00, norm01, norm10, norm11;
   logic        accept;

   // The ready path must never be asserted while the engine is being reset.
   assign sym_ready = ((state == StIdle) | ((state == StOut) & met_ready)) & ~sys_rst;
   assign accept    = sym_valid & sym_ready;

   // idx[1] selects I/Q, idx[0] selects the complementary distance (255-x == ~x).
   always_comb begin
      sq_op  = idx[1] ? lat_q : lat_i;
      if (idx[0]) begin
         sq_op = ~sq_op;
      end
      sq_res = 16'(sq_op) * 16'(sq_op);
   end

   always_comb begin
      sum00   = {1'b0, sq0} + {1'b0, sq2};
      sum01   = {1'b0, sq0} + {1'b0, sq3};
      sum10   = {1'b0, sq1} + {1'b0, sq2};
      sum11   = {1'b0, sq1} + {1'b0, sq3};
      min_lo  = (sum00 < sum01) ? sum00 : sum01;
      min_hi  = (sum10 < sum11) ? sum10 : sum11;
      min_all = (min_lo < min_hi) ? min_lo : min_hi;
      if (NORMALIZE) begin
         norm00 = sum00 - min_all;
         norm01 = sum01 - min_all;
         norm10 = sum10 - min_all;
         norm11 = sum11 - min_all;
      end else begin
         norm00 = sum00;
         norm01 = sum01;
         norm10 = sum10;
         norm11 = sum11;
      end
   end

   always_ff @(posedge clk) begin
      if (sys_rst) begin
         state     <= StIdle;
         idx       <= 2'd0;
         lat_i     <= 8'd0;
         lat_q     <= 8'd0;
         sq0       <= 16'd0;
         sq1       <= 16'd0;
         sq2       <= 16'd0;
         sq3       <= 16'd0;
         cnt       <= '0;
         met_00    <= '0;
         met_01    <= '0;
         met_10    <= '0;
         met_11    <= '0;
         met_valid <= 1'b0;
         blk_end   <= 1'b0;
      end else begin
         unique case (state)
            StIdle: begin
               if (accept) begin
                  lat_i <= sym_i;
                  lat_q <= sym_q;
                  idx   <= 2'd0;
                  state <= StSq;
               end
            end
            StSq: begin
               unique case (idx)
                  2'd0: sq0 <= sq_res;
                  2'd1: sq1 <= sq_res;
                  2'd2: sq2 <= sq_res;
                  2'd3: sq3 <= sq_res;
               endcase
               idx <= idx + 2'd1;
               if (idx == 2'd3) begin
                  state <= StSum;
               end
            end
            StSum: begin
               met_00    <= STATE_MET_WIDTH'(norm00);
               met_01    <= STATE_MET_WIDTH'(norm01);
               met_10    <= STATE_MET_WIDTH'(norm10);
               met_11    <= STATE_MET_WIDTH'(norm11);
               met_valid <= 1'b1;
               blk_end   <= (cnt == CntLast);
               state     <= StOut;
            end
            StOut: begin
               if (met_ready) begin
                  met_valid <= 1'b0;
                  blk_end   <= 1'b0;
                  cnt       <= (cnt == CntLast) ? '0 : cnt + 1'b1;
                  if (sym_valid) begin
                     lat_i <= sym_i;
                     lat_q <= sym_q;
                     idx   <= 2'd0;
                     state <= StSq;
                  end else begin
                     state <= StIdle;
                  end
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_bmu_sched.sv
// Randomised bench for bmu_sched: a plain-arithmetic metric model, a symbol queue
// and a transfer counter predict every metric set and block-end flag.
module tb_bmu_sched;

   localparam int unsigned W  = 20;
   localparam int unsigned BL = 4;

   logic         clk = 1'b0;
   logic         sys_rst = 1'b1;
   logic [7:0]   sym_i = 8'd0;
   logic [7:0]   sym_q = 8'd0;
   logic         sym_valid = 1'b0;
   logic         met_ready = 1'b0;
   logic         sym_ready, sym_ready_n;
   logic [W-1:0] met_00, met_01, met_10, met_11;
   logic [W-1:0] nmet_00, nmet_01, nmet_10, nmet_11;
   logic         met_valid, met_valid_n, blk_end, blk_end_n;

   int total = 0;
   int bad   = 0;
   int xfers = 0;

   bmu_sched #(.STATE_MET_WIDTH(W), .BLOCK_LEN(BL), .NORMALIZE(1'b0)) u_dut (
      .clk(clk), .sys_rst(sys_rst), .sym_i(sym_i), .sym_q(sym_q), .sym_valid(sym_valid),
      .sym_ready(sym_ready), .met_00(met_00), .met_01(met_01), .met_10(met_10),
      .met_11(met_11), .met_valid(met_valid), .met_ready(met_ready), .blk_end(blk_end)
   );

   bmu_sched #(.STATE_MET_WIDTH(W), .BLOCK_LEN(BL), .NORMALIZE(1'b1)) u_dut_n (
      .clk(clk), .sys_rst(sys_rst), .sym_i(sym_i), .sym_q(sym_q), .sym_valid(sym_valid),
      .sym_ready(sym_ready_n), .met_00(nmet_00), .met_01(nmet_01), .met_10(nmet_10),
      .met_11(nmet_11), .met_valid(met_valid_n), .met_ready(met_ready), .blk_end(blk_end_n)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Squared Euclidean distance of (i,q) to the four ideal points (0/255 per axis).
   function automatic int unsigned exp_met(input int unsigned i, input int unsigned q,
                                           input int k, input bit norm);
      int unsigned m[4];
      int unsigned mn;
      m[0] = i * i + q * q;
      m[1] = i * i + (255 - q) * (255 - q);
      m[2] = (255 - i) * (255 - i) + q * q;
      m[3] = (255 - i) * (255 - i) + (255 - q) * (255 - q);
      mn = m[0];
      for (int j = 1; j < 4; j++) if (m[j] < mn) mn = m[j];
      return norm ? m[k] - mn : m[k];
   endfunction

   task automatic check_outputs(input int unsigned i, input int unsigned q);
      bit blk;
      blk = ((xfers % BL) == BL - 1);
      check("met_valid", met_valid, 1);
      check("met_valid_n", met_valid_n, 1);
      check("met_00", met_00, exp_met(i, q, 0, 0));
      check("met_01", met_01, exp_met(i, q, 1, 0));
      check("met_10", met_10, exp_met(i, q, 2, 0));
      check("met_11", met_11, exp_met(i, q, 3, 0));
      check("nmet_00", nmet_00, exp_met(i, q, 0, 1));
      check("nmet_01", nmet_01, exp_met(i, q, 1, 1));
      check("nmet_10", nmet_10, exp_met(i, q, 2, 1));
      check("nmet_11", nmet_11, exp_met(i, q, 3, 1));
      check("blk_end", blk_end, blk);
      check("blk_end_n", blk_end_n, blk);
   endtask

   // One symbol through the engine, with met_ready withheld for 'hold' cycles.
   task automatic send(input int unsigned i, input int unsigned q, input int hold);
      int n;
      sym_i = 8'(i);
      sym_q = 8'(q);
      sym_valid = 1'b1;
      n = 0;
      while (!sym_ready && n < 20) begin
         step();
         n++;
      end
      if (!sym_ready) begin
         check("accept_timeout", 0, 1);
         sym_valid = 1'b0;
         return;
      end
      step();
      sym_valid = 1'b0;
      n = 0;
      while (!met_valid && n < 20) begin
         step();
         n++;
      end
      check("latency", n, 5);
      check_outputs(i, q);
      check("ready_in_out", sym_ready, 0);
      for (int h = 0; h < hold; h++) begin
         step();
         check_outputs(i, q);
         check("ready_hold", sym_ready, 0);
      end
      met_ready = 1'b1;
      #1;
      check("ready_xfer", sym_ready, 1);
      step();
      met_ready = 1'b0;
      xfers++;
      check("valid_after_xfer", met_valid, 0);
      check("blk_after_xfer", blk_end, 0);
   endtask

   initial begin
      int unsigned qi[$];
      int unsigned qq[$];
      int sent, got, last_acc, nb2b;
      bit acc;

      repeat (3) step();
      check("rst_ready", sym_ready, 0);
      check("rst_valid", met_valid, 0);
      check("rst_blk", blk_end, 0);
      check("rst_met00", met_00, 0);
      check("rst_nmet11", nmet_11, 0);
      sys_rst = 1'b0;
      #1;
      check("idle_ready", sym_ready, 1);

      send(0, 0, 0);
      send(128, 64, 10);
      for (int k = 0; k < 6; k++) send($urandom_range(0, 255), $urandom_range(0, 255),
                                       int'($urandom_range(0, 3)));

      // Streaming: sym_valid held, met_ready held, new data only after each accept.
      nb2b = 7;
      sent = 0;
      got = 0;
      last_acc = -1;
      met_ready = 1'b1;
      sym_i = 8'($urandom_range(0, 255));
      sym_q = 8'($urandom_range(0, 255));
      sym_valid = 1'b1;
      for (int cyc = 1; cyc <= 200 && got < nb2b; cyc++) begin
         acc = sym_valid && sym_ready;
         step();
         if (acc) begin
            qi.push_back(int'(sym_i));
            qq.push_back(int'(sym_q));
            if (last_acc >= 0) check("b2b_period", cyc - last_acc, 6);
            last_acc = cyc;
            sent++;
            if (sent < nb2b) begin
               sym_i = 8'($urandom_range(0, 255));
               sym_q = 8'($urandom_range(0, 255));
            end else begin
               sym_valid = 1'b0;
            end
         end
         if (met_valid) begin
            if (qi.size() == 0) begin
               check("b2b_extra_output", 1, 0);
            end else begin
               check_outputs(qi.pop_front(), qq.pop_front());
               xfers++;
            end
            got++;
         end
      end
      check("b2b_count", got, nb2b);
      step();
      met_ready = 1'b0;
      sym_valid = 1'b0;

      // Reset while the squarer is on idx2.
      sym_i = 8'd77;
      sym_q = 8'd200;
      sym_valid = 1'b1;
      #1;
      check("pre_rst_ready", sym_ready, 1);
      step();
      sym_valid = 1'b0;
      step();
      step();
      sys_rst = 1'b1;
      #1;
      check("mid_rst_ready", sym_ready, 0);
      step();
      sys_rst = 1'b0;
      #1;
      check("post_rst_ready", sym_ready, 1);
      for (int k = 0; k < 8; k++) begin
         step();
         check("post_rst_valid", met_valid, 0);
      end
      xfers = 0;
      for (int k = 0; k < 5; k++) send($urandom_range(0, 255), $urandom_range(0, 255), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
